// File: rtl/jpeg_pkg.sv
// Shared constants for the DCT quantizer: lane geometry, FSM states and the
// JPEG luminance/chrominance quantization tables with their 1/Q reciprocals.
package jpeg_pkg;

  localparam int COEF_W  = 10;
  localparam int QOUT_W  = 8;
  localparam int LANES   = 8;
  localparam int RECIP_W = 17;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  // Row-major 8x8 tables; entry [u*8+v] is row u, column v.
  localparam logic [0:63][7:0] LUM_Q = {
    8'd16, 8'd11, 8'd10, 8'd16, 8'd24,  8'd40,  8'd51,  8'd61,
    8'd12, 8'd12, 8'd14, 8'd19, 8'd26,  8'd58,  8'd60,  8'd55,
    8'd14, 8'd13, 8'd16, 8'd24, 8'd40,  8'd57,  8'd69,  8'd56,
    8'd14, 8'd17, 8'd22, 8'd29, 8'd51,  8'd87,  8'd80,  8'd62,
    8'd18, 8'd22, 8'd37, 8'd56, 8'd68,  8'd109, 8'd103, 8'd77,
    8'd24, 8'd35, 8'd55, 8'd64, 8'd81,  8'd104, 8'd113, 8'd92,
    8'd49, 8'd64, 8'd78, 8'd87, 8'd103, 8'd121, 8'd120, 8'd101,
    8'd72, 8'd92, 8'd95, 8'd98, 8'd112, 8'd100, 8'd103, 8'd99
  };

  localparam logic [0:63][7:0] CHR_Q = {
    8'd17, 8'd18, 8'd24, 8'd47, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd18, 8'd21, 8'd26, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd24, 8'd26, 8'd56, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd47, 8'd66, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99,
    8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99, 8'd99
  };

  // Evaluated at elaboration only: round(65536/Q), so no divider reaches hardware.
  function automatic logic [0:63][RECIP_W-1:0] calc_recip(input logic [0:63][7:0] q);
    logic [0:63][RECIP_W-1:0] r;
    for (int i = 0; i < 64; i++)
      r[i] = RECIP_W'((32'd65536 + 32'(q[i] >> 1)) / 32'(q[i]));
    return r;
  endfunction

  localparam logic [0:63][RECIP_W-1:0] LUM_R = calc_recip(LUM_Q);
  localparam logic [0:63][RECIP_W-1:0] CHR_R = calc_recip(CHR_Q);

  function automatic logic [RECIP_W-1:0] recip_lookup(input int sel, input logic [2:0] u,
                                                      input logic [2:0] v);
    logic [5:0] idx;
    idx = {u, v};
    case (sel)
      0:       return LUM_R[idx];
      1:       return CHR_R[idx];
      default: return RECIP_W'(65536);
    endcase
  endfunction

endpackage

// File: rtl/quant_lane.sv
// One coefficient lane: sign-magnitude multiply by the reciprocal, round half
// away from zero, saturate to a signed 8-bit result.
module quant_lane
  import jpeg_pkg::*;
(
  input  logic signed [COEF_W-1:0]  c,
  input  logic        [RECIP_W-1:0] r,
  output logic signed [QOUT_W-1:0]  q
);

  logic signed [COEF_W:0] cx;
  logic        [COEF_W:0] m;
  logic        [27:0]     p;
  logic        [11:0]     qm;

  function automatic logic signed [QOUT_W-1:0] sat_q(input logic neg, input logic [11:0] mag);
    logic [11:0] neg_mag;
    neg_mag = ~mag + 12'd1;
    if (!neg)
      return (mag > 12'd127) ? 8'sd127 : mag[QOUT_W-1:0];
    else
      return (mag > 12'd128) ? -8'sd128 : neg_mag[QOUT_W-1:0];
  endfunction

  // Magnitude is taken in 11 bits so -512 maps to +512 without overflow.
  always_comb begin
    cx = {c[COEF_W-1], c};
    m  = cx[COEF_W] ? $unsigned(-cx) : $unsigned(cx);
    p  = 28'(m) * 28'(r) + 28'd32768;
    qm = p[27:16];
    q  = sat_q(c[COEF_W-1], qm);
  end

endmodule

// File: rtl/dct_quantizer.sv
// Streams DCT coefficient rows from SRAM, quantizes each lane by the JPEG
// table entry for its (row, column), and writes 8-bit rows back out.
module dct_quantizer
  import jpeg_pkg::*;
#(
  parameter int NUM_ROWS     = 32768,
  parameter int ADDR_W       = 15,
  parameter int READ_LATENCY = 1,
  parameter int QTAB_SEL     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [LANES*COEF_W-1:0]   rd_data,
  output logic                      wr_en,
  output logic [ADDR_W-1:0]         wr_addr,
  output logic [LANES*QOUT_W-1:0]   wr_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_ROWS - 1);

  state_t                    state;
  logic [READ_LATENCY-1:0]   vld_p0;
  logic [ADDR_W-1:0]         addr_p0 [READ_LATENCY];
  logic                      vld_p1;
  logic [ADDR_W-1:0]         addr_p1;
  logic [LANES*COEF_W-1:0]   data_p1;
  logic [RECIP_W-1:0]        r_p1 [LANES];
  logic [LANES*QOUT_W-1:0]   q_p1;

  // Completion is keyed on the last row actually being written, not on a cycle count.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state   <= S_READ;
          busy    <= 1'b1;
          rd_en   <= 1'b1;
          rd_addr <= '0;
        end
        S_READ: begin
          if (rd_addr == LAST) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: if (wr_en && wr_addr == LAST) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p0: read-latency shift register; p1: captured row; then output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0  <= '0;
      vld_p1  <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      vld_p0[0] <= rd_en;
      for (int i = 1; i < READ_LATENCY; i++) vld_p0[i] <= vld_p0[i-1];
      vld_p1 <= vld_p0[READ_LATENCY-1];
      wr_en  <= vld_p1;
      if (vld_p1) begin
        wr_addr <= addr_p1;
        wr_data <= q_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    addr_p0[0] <= rd_addr;
    for (int i = 1; i < READ_LATENCY; i++) addr_p0[i] <= addr_p0[i-1];
    data_p1 <= rd_data;
    addr_p1 <= addr_p0[READ_LATENCY-1];
  end

  // Stage p1 -> p2: per-lane quantization; table row is the row index within the 8x8 block.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign r_p1[k] = recip_lookup(QTAB_SEL, addr_p1[2:0], 3'(k));
    quant_lane u_lane (
      .c (data_p1[k*COEF_W +: COEF_W]),
      .r (r_p1[k]),
      .q (q_p1[k*QOUT_W +: QOUT_W])
    );
  end

endmodule
